// File: rtl/onchip_memory_dp.sv
// Dual-slave Avalon-MM on-chip RAM: two independent slaves on one true-dual-port array.
// Define ONCHIP_MEMORY_DP_CLEAR_ON_RESET_EN to zero-fill the whole array after every reset.
module onchip_memory_dp #(
  parameter int DATA_W       = 32,
  parameter int BE_W         = DATA_W / 8,
  parameter int DEPTH        = 3125,
  parameter int ADDR_W       = 12,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = "onchip_memory_dp.hex"
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clken,
  input  logic              reset_req,

  input  logic [ADDR_W-1:0] s1_address,
  input  logic [BE_W-1:0]   s1_byteenable,
  input  logic              s1_chipselect,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [DATA_W-1:0] s1_writedata,
  output logic [DATA_W-1:0] s1_readdata,
  output logic              s1_readdatavalid,
  output logic              s1_waitrequest,

  input  logic [ADDR_W-1:0] s2_address,
  input  logic [BE_W-1:0]   s2_byteenable,
  input  logic              s2_chipselect,
  input  logic              s2_read,
  input  logic              s2_write,
  input  logic [DATA_W-1:0] s2_writedata,
  output logic [DATA_W-1:0] s2_readdata,
  output logic              s2_readdatavalid,
  output logic              s2_waitrequest
);

  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("onchip_memory_dp: DATA_W must be a multiple of 8");
  end
  if (BE_W * 8 != DATA_W) begin : g_bad_be_w
    $error("onchip_memory_dp: BE_W must equal DATA_W/8");
  end
  if ((64'd1 << ADDR_W) < 64'(DEPTH)) begin : g_bad_addr_w
    $error("onchip_memory_dp: ADDR_W too narrow for DEPTH");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("onchip_memory_dp: READ_LATENCY must be 1 or 2");
  end

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_READY = 2'd2;
`ifdef ONCHIP_MEMORY_DP_CLEAR_ON_RESET_EN
  localparam logic [1:0]        ST_CLEAR  = 2'd1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
`endif
  // One extra bit so DEPTH == 2^ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        state;
  logic              ready;
  logic              adv;
  logic              en;

  logic              s1_wr;
  logic              s1_rd;
  logic              s1_in_range;
  logic              s2_wr;
  logic              s2_rd;
  logic              s2_in_range;

  logic              p1_we;
  logic [ADDR_W-1:0] p1_wa;
  logic [DATA_W-1:0] p1_wd;
  logic [BE_W-1:0]   p1_be;
  logic              p2_we;
  logic [BE_W-1:0]   p2_be;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              s1_vld_p0;
  logic              s2_vld_p0;
  logic [DATA_W-1:0] s1_rdata_p0;
  logic [DATA_W-1:0] s2_rdata_p0;
  logic              s1_vld_out;
  logic              s2_vld_out;
  logic [DATA_W-1:0] s1_rdata_out;
  logic [DATA_W-1:0] s2_rdata_out;

  // adv: the pipeline may move this cycle; en additionally requires the READY state.
  assign ready = (state == ST_READY);
  assign adv   = clken & ~reset_req & ~reset;
  assign en    = adv & ready;

  assign s1_waitrequest = ~en;
  assign s2_waitrequest = ~en;

  // A write on the same port as a read wins; the read is dropped without a valid.
  assign s1_wr       = s1_chipselect & s1_write & en;
  assign s1_rd       = s1_chipselect & s1_read & ~s1_write & en;
  assign s1_in_range = ({1'b0, s1_address} < DEPTH_X);
  assign s2_wr       = s2_chipselect & s2_write & en;
  assign s2_rd       = s2_chipselect & s2_read & ~s2_write & en;
  assign s2_in_range = ({1'b0, s2_address} < DEPTH_X);

`ifdef ONCHIP_MEMORY_DP_CLEAR_ON_RESET_EN
  logic [ADDR_W-1:0] clr_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_RESET;
      clr_addr <= '0;
    end else begin
      case (state)
        ST_RESET: begin
          state    <= ST_CLEAR;
          clr_addr <= '0;
        end
        ST_CLEAR: begin
          if (adv) begin
            if (clr_addr == LAST_ADDR) begin
              state <= ST_READY;
            end else begin
              clr_addr <= clr_addr + 1'b1;
            end
          end
        end
        ST_READY: state <= ST_READY;
        default:  state <= ST_RESET;
      endcase
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RESET;
    end else begin
      case (state)
        ST_RESET: state <= ST_READY;
        ST_READY: state <= ST_READY;
        default:  state <= ST_RESET;
      endcase
    end
  end
`endif

  // Port 1 write path also carries the clear sweep; s1 owns lanes both ports enable.
  always_comb begin
    p1_we = s1_wr & s1_in_range;
    p1_wa = s1_address;
    p1_wd = s1_writedata;
    p1_be = s1_byteenable;
`ifdef ONCHIP_MEMORY_DP_CLEAR_ON_RESET_EN
    if (state == ST_CLEAR && adv) begin
      p1_we = 1'b1;
      p1_wa = clr_addr;
      p1_wd = '0;
      p1_be = '1;
    end
`endif
    p2_we = s2_wr & s2_in_range;
    p2_be = s2_byteenable;
    if (p1_we && p2_we && (p1_wa == s2_address)) begin
      p2_be = s2_byteenable & ~p1_be;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (p1_we && p1_be[i]) begin
        mem[p1_wa][i*8 +: 8] <= p1_wd[i*8 +: 8];
      end
      if (p2_we && p2_be[i]) begin
        mem[s2_address][i*8 +: 8] <= s2_writedata[i*8 +: 8];
      end
    end
  end

  // Stage p0: registered array read (old data on a same-cycle write).
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_p0   <= 1'b0;
      s2_vld_p0   <= 1'b0;
      s1_rdata_p0 <= '0;
      s2_rdata_p0 <= '0;
    end else if (adv) begin
      s1_vld_p0 <= s1_rd;
      s2_vld_p0 <= s2_rd;
      if (s1_rd) begin
        s1_rdata_p0 <= s1_in_range ? mem[s1_address] : '0;
      end
      if (s2_rd) begin
        s2_rdata_p0 <= s2_in_range ? mem[s2_address] : '0;
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic              s1_vld_p1;
    logic              s2_vld_p1;
    logic [DATA_W-1:0] s1_rdata_p1;
    logic [DATA_W-1:0] s2_rdata_p1;

    // Stage p1: optional output register.
    always_ff @(posedge clk) begin
      if (reset) begin
        s1_vld_p1   <= 1'b0;
        s2_vld_p1   <= 1'b0;
        s1_rdata_p1 <= '0;
        s2_rdata_p1 <= '0;
      end else if (adv) begin
        s1_vld_p1 <= s1_vld_p0;
        s2_vld_p1 <= s2_vld_p0;
        if (s1_vld_p0) begin
          s1_rdata_p1 <= s1_rdata_p0;
        end
        if (s2_vld_p0) begin
          s2_rdata_p1 <= s2_rdata_p0;
        end
      end
    end

    assign s1_vld_out   = s1_vld_p1;
    assign s2_vld_out   = s2_vld_p1;
    assign s1_rdata_out = s1_rdata_p1;
    assign s2_rdata_out = s2_rdata_p1;
  end else begin : g_lat1
    assign s1_vld_out   = s1_vld_p0;
    assign s2_vld_out   = s2_vld_p0;
    assign s1_rdata_out = s1_rdata_p0;
    assign s2_rdata_out = s2_rdata_p0;
  end

  // A held valid is shown only on a cycle the pipeline advances, so it is seen exactly once.
  assign s1_readdatavalid = s1_vld_out & adv;
  assign s2_readdatavalid = s2_vld_out & adv;
  assign s1_readdata      = s1_rdata_out;
  assign s2_readdata      = s2_rdata_out;

endmodule

// File: tb/tb_onchip_memory_dp.sv
// Directed bench for onchip_memory_dp; drives a READ_LATENCY=1 and a READ_LATENCY=2 instance in lockstep.
module tb_onchip_memory_dp;

  localparam int DEPTH = 3125;

`ifdef ONCHIP_MEMORY_DP_CLEAR_ON_RESET_EN
  localparam int          EXP_SWEEP = 3125;
  localparam logic [31:0] EXP_FILL  = 32'h0000_0000;
`else
  localparam int          EXP_SWEEP = 0;
  localparam logic [31:0] EXP_FILL  = 32'h1234_5678;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        clken;
  logic        reset_req;
  logic [11:0] s1_address;
  logic [3:0]  s1_byteenable;
  logic        s1_chipselect;
  logic        s1_read;
  logic        s1_write;
  logic [31:0] s1_writedata;
  logic [11:0] s2_address;
  logic [3:0]  s2_byteenable;
  logic        s2_chipselect;
  logic        s2_read;
  logic        s2_write;
  logic [31:0] s2_writedata;

  logic [31:0] l1_s1_readdata, l1_s2_readdata, l2_s1_readdata, l2_s2_readdata;
  logic        l1_s1_readdatavalid, l1_s2_readdatavalid, l2_s1_readdatavalid, l2_s2_readdatavalid;
  logic        l1_s1_waitrequest, l1_s2_waitrequest, l2_s1_waitrequest, l2_s2_waitrequest;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  onchip_memory_dp #(.READ_LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_readdata(l1_s1_readdata), .s1_readdatavalid(l1_s1_readdatavalid),
    .s1_waitrequest(l1_s1_waitrequest),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_readdata(l1_s2_readdata), .s2_readdatavalid(l1_s2_readdatavalid),
    .s2_waitrequest(l1_s2_waitrequest)
  );

  onchip_memory_dp #(.READ_LATENCY(2)) dut_l2 (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_readdata(l2_s1_readdata), .s1_readdatavalid(l2_s1_readdatavalid),
    .s1_waitrequest(l2_s1_waitrequest),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_readdata(l2_s2_readdata), .s2_readdatavalid(l2_s2_readdatavalid),
    .s2_waitrequest(l2_s2_waitrequest)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_address = '0; s1_byteenable = '0; s1_writedata = '0;
    s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_address = '0; s2_byteenable = '0; s2_writedata = '0;
  endtask

  task automatic write1(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    s1_chipselect = 1; s1_write = 1; s1_address = a; s1_writedata = d; s1_byteenable = be;
    tick();
    idle();
  endtask

  task automatic write2(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    s2_chipselect = 1; s2_write = 1; s2_address = a; s2_writedata = d; s2_byteenable = be;
    tick();
    idle();
  endtask

  // Issues one s1 read and returns at the negedge right after the accepting edge.
  task automatic read1(input logic [11:0] a);
    s1_chipselect = 1; s1_read = 1; s1_address = a;
    tick();
    idle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    idle();
    clken = 1; reset_req = 0; reset = 1;
    tick();
    tick();
    @(negedge clk);
    checks++; if (l1_s1_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wr_l1s1: got %b need 1", l1_s1_waitrequest); end
    checks++; if (l1_s2_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wr_l1s2: got %b need 1", l1_s2_waitrequest); end
    checks++; if (l2_s1_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wr_l2s1: got %b need 1", l2_s1_waitrequest); end
    checks++; if (l1_s1_readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_rdv_l1s1: got %b need 0", l1_s1_readdatavalid); end
    checks++; if (l2_s2_readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_rdv_l2s2: got %b need 0", l2_s2_readdatavalid); end
    checks++; if (l1_s1_readdata !== 32'h0) begin errors++; $display("FAIL reset_rd_l1s1: got %h need 0", l1_s1_readdata); end
    checks++; if (l2_s2_readdata !== 32'h0) begin errors++; $display("FAIL reset_rd_l2s2: got %h need 0", l2_s2_readdata); end
    reset = 0;
    tick();
    n = 0;
    while (l1_s1_waitrequest === 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    checks++; if (n != EXP_SWEEP) begin errors++; $display("FAIL reset_sweep_len: got %0d need %0d", n, EXP_SWEEP); end
    @(negedge clk);
    checks++; if (l2_s2_waitrequest !== 1'b0) begin errors++; $display("FAIL ready_wr_l2s2: got %b need 0", l2_s2_waitrequest); end
    tick();
  endtask

  task automatic test_write_read();
    write1(12'd5, 32'hDEAD_BEEF, 4'hF);
    read1(12'd5);
    checks++; if (l1_s1_readdatavalid !== 1'b1) begin errors++; $display("FAIL lat1_rdv: got %b need 1", l1_s1_readdatavalid); end
    checks++; if (l1_s1_readdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lat1_data: got %h need deadbeef", l1_s1_readdata); end
    checks++; if (l2_s1_readdatavalid !== 1'b0) begin errors++; $display("FAIL lat2_early_rdv: got %b need 0", l2_s1_readdatavalid); end
    @(negedge clk);
    checks++; if (l1_s1_readdatavalid !== 1'b0) begin errors++; $display("FAIL lat1_rdv_pulse: got %b need 0", l1_s1_readdatavalid); end
    checks++; if (l1_s1_readdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lat1_hold: got %h need deadbeef", l1_s1_readdata); end
    checks++; if (l2_s1_readdatavalid !== 1'b1) begin errors++; $display("FAIL lat2_rdv: got %b need 1", l2_s1_readdatavalid); end
    checks++; if (l2_s1_readdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lat2_data: got %h need deadbeef", l2_s1_readdata); end
    tick();
    // read and write together: write lands, read produces no valid
    s1_chipselect = 1; s1_read = 1; s1_write = 1; s1_address = 12'd6;
    s1_writedata = 32'h600D_600D; s1_byteenable = 4'hF;
    tick();
    idle();
    @(negedge clk);
    checks++; if (l1_s1_readdatavalid !== 1'b0) begin errors++; $display("FAIL rw_no_rdv_l1: got %b need 0", l1_s1_readdatavalid); end
    @(negedge clk);
    checks++; if (l2_s1_readdatavalid !== 1'b0) begin errors++; $display("FAIL rw_no_rdv_l2: got %b need 0", l2_s1_readdatavalid); end
    tick();
    read1(12'd6);
    checks++; if (l1_s1_readdata !== 32'h600D_600D) begin errors++; $display("FAIL rw_write_done: got %h need 600d600d", l1_s1_readdata); end
    tick();
  endtask

  task automatic test_collision();
    s1_chipselect = 1; s1_write = 1; s1_address = 12'd9; s1_writedata = 32'h1122_3344; s1_byteenable = 4'h3;
    s2_chipselect = 1; s2_write = 1; s2_address = 12'd9; s2_writedata = 32'hAABB_CCDD; s2_byteenable = 4'hE;
    tick();
    idle();
    read1(12'd9);
    checks++; if (l1_s1_readdata !== 32'hAABB_3344) begin errors++; $display("FAIL collision_l1: got %h need aabb3344", l1_s1_readdata); end
    @(negedge clk);
    checks++; if (l2_s1_readdata !== 32'hAABB_3344) begin errors++; $display("FAIL collision_l2: got %h need aabb3344", l2_s1_readdata); end
    tick();
  endtask

  task automatic test_mixed_port();
    write1(12'd7, 32'h0, 4'hF);
    s1_chipselect = 1; s1_write = 1; s1_address = 12'd7; s1_writedata = 32'h5A5A_5A5A; s1_byteenable = 4'hF;
    s2_chipselect = 1; s2_read = 1; s2_address = 12'd7;
    tick();
    idle();
    @(negedge clk);
    checks++; if (l1_s2_readdatavalid !== 1'b1) begin errors++; $display("FAIL mixed_rdv: got %b need 1", l1_s2_readdatavalid); end
    checks++; if (l1_s2_readdata !== 32'h0) begin errors++; $display("FAIL mixed_old_l1: got %h need 0", l1_s2_readdata); end
    @(negedge clk);
    checks++; if (l2_s2_readdata !== 32'h0) begin errors++; $display("FAIL mixed_old_l2: got %h need 0", l2_s2_readdata); end
    tick();
    s2_chipselect = 1; s2_read = 1; s2_address = 12'd7;
    tick();
    idle();
    @(negedge clk);
    checks++; if (l1_s2_readdata !== 32'h5A5A_5A5A) begin errors++; $display("FAIL mixed_new: got %h need 5a5a5a5a", l1_s2_readdata); end
    tick();
  endtask

  task automatic test_out_of_range();
    write1(12'd3124, 32'hCAFE_F00D, 4'hF);
    write1(12'd3125, 32'hFFFF_FFFF, 4'hF);
    read1(12'd3125);
    checks++; if (l1_s1_readdatavalid !== 1'b1) begin errors++; $display("FAIL oor_rdv_l1: got %b need 1", l1_s1_readdatavalid); end
    checks++; if (l1_s1_readdata !== 32'h0) begin errors++; $display("FAIL oor_data_l1: got %h need 0", l1_s1_readdata); end
    @(negedge clk);
    checks++; if (l2_s1_readdatavalid !== 1'b1) begin errors++; $display("FAIL oor_rdv_l2: got %b need 1", l2_s1_readdatavalid); end
    checks++; if (l2_s1_readdata !== 32'h0) begin errors++; $display("FAIL oor_data_l2: got %h need 0", l2_s1_readdata); end
    tick();
    read1(12'd3124);
    checks++; if (l1_s1_readdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL oor_neighbour: got %h need cafef00d", l1_s1_readdata); end
    tick();
  endtask

  task automatic test_back_to_back_freeze();
    logic [11:0] addr_tab [7] = '{12'd0, 12'd1, 12'd2, 12'd2, 12'd2, 12'd2, 12'd3};
    logic        ck_tab   [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int n1;
    int n2;
    for (int i = 0; i < 4; i++) write2(12'(i), 32'hB0B0_0000 + 32'(i), 4'hF);
    n1 = 0;
    n2 = 0;
    for (int c = 0; c < 11; c++) begin
      if (c < 7) begin
        s2_chipselect = 1; s2_read = 1; s2_address = addr_tab[c]; clken = ck_tab[c];
      end else begin
        idle(); clken = 1;
      end
      @(negedge clk);
      checks++; if (l1_s2_waitrequest !== ~clken) begin errors++; $display("FAIL b2b_wr c%0d: got %b need %b", c, l1_s2_waitrequest, ~clken); end
      if (clken == 1'b0) begin
        checks++; if (l1_s2_readdatavalid !== 1'b0 || l2_s2_readdatavalid !== 1'b0) begin errors++; $display("FAIL b2b_frozen_rdv c%0d: got %b%b need 00", c, l1_s2_readdatavalid, l2_s2_readdatavalid); end
      end
      if (l1_s2_readdatavalid === 1'b1) begin
        checks++; if (l1_s2_readdata !== 32'hB0B0_0000 + 32'(n1)) begin errors++; $display("FAIL b2b_order_l1 #%0d: got %h need %h", n1, l1_s2_readdata, 32'hB0B0_0000 + 32'(n1)); end
        n1++;
      end
      if (l2_s2_readdatavalid === 1'b1) begin
        checks++; if (l2_s2_readdata !== 32'hB0B0_0000 + 32'(n2)) begin errors++; $display("FAIL b2b_order_l2 #%0d: got %h need %h", n2, l2_s2_readdata, 32'hB0B0_0000 + 32'(n2)); end
        n2++;
      end
      tick();
    end
    checks++; if (n1 != 4) begin errors++; $display("FAIL b2b_count_l1: got %0d need 4", n1); end
    checks++; if (n2 != 4) begin errors++; $display("FAIL b2b_count_l2: got %0d need 4", n2); end
    reset_req = 1;
    @(negedge clk);
    checks++; if (l1_s1_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_req_wr_l1: got %b need 1", l1_s1_waitrequest); end
    checks++; if (l2_s2_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_req_wr_l2: got %b need 1", l2_s2_waitrequest); end
    tick();
    reset_req = 0;
    tick();
  endtask

  task automatic test_clear_on_reset();
    int n;
    for (int a = 0; a < DEPTH; a += 2) begin
      s1_chipselect = 1; s1_write = 1; s1_address = 12'(a); s1_writedata = 32'h1234_5678; s1_byteenable = 4'hF;
      if (a + 1 < DEPTH) begin
        s2_chipselect = 1; s2_write = 1; s2_address = 12'(a + 1); s2_writedata = 32'h1234_5678; s2_byteenable = 4'hF;
      end else begin
        s2_chipselect = 0; s2_write = 0;
      end
      tick();
    end
    idle();
    reset = 1;
    tick();
    reset = 0;
    repeat (1001) tick();
    reset = 1;
    tick();
    reset = 0;
    tick();
    n = 0;
    while (l1_s1_waitrequest === 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    checks++; if (n != EXP_SWEEP) begin errors++; $display("FAIL clear_sweep_len: got %0d need %0d", n, EXP_SWEEP); end
    read1(12'd0);
    checks++; if (l1_s1_readdata !== EXP_FILL) begin errors++; $display("FAIL clear_addr0: got %h need %h", l1_s1_readdata, EXP_FILL); end
    tick();
    read1(12'd1500);
    checks++; if (l1_s1_readdata !== EXP_FILL) begin errors++; $display("FAIL clear_addr1500: got %h need %h", l1_s1_readdata, EXP_FILL); end
    tick();
    read1(12'd3124);
    checks++; if (l1_s1_readdata !== EXP_FILL) begin errors++; $display("FAIL clear_addr3124: got %h need %h", l1_s1_readdata, EXP_FILL); end
    @(negedge clk);
    checks++; if (l2_s1_readdata !== EXP_FILL) begin errors++; $display("FAIL clear_addr3124_l2: got %h need %h", l2_s1_readdata, EXP_FILL); end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_mixed_port();
    test_out_of_range();
    test_back_to_back_freeze();
    test_clear_on_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
